// File: rtl/miriscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package miriscv_lsu_pkg;

  localparam int unsigned XLEN = 32;

  // funct3 access size codes
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_e;

  // Request payload presented on the data bus
  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_bus_req_t;

  // Natural alignment check; unknown size codes behave as word accesses
  function automatic logic lsu_is_aligned(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      MEM_B, MEM_BU: ok = 1'b1;
      MEM_H, MEM_HU: ok = ~off[0];
      default:       ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/miriscv_lsu_load_ext.sv
// Load lane selection and sign/zero extension of the returned bus word.
module miriscv_lsu_load_ext
  import miriscv_lsu_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_size,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_lane;

  // Shift the addressed byte lane down to bit 0, then extend per access size
  always_comb begin
    w_lane = i_rdata >> {i_off, 3'b000};
    case (i_size)
      MEM_B:   o_result = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      MEM_BU:  o_result = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      MEM_H:   o_result = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      MEM_HU:  o_result = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      default: o_result = w_lane;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: single-outstanding req/gnt/rvalid data bus master with
// alignment check, byte-lane generation, load extension and bus timeout.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 256
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_size_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_done_o,
  output logic            lsu_stall_req_o,
  output logic            lsu_misalign_o,
  output logic            lsu_bus_err_o,
  output logic            data_req_o,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic [XLEN-1:0] data_addr_o,
  output logic [XLEN-1:0] data_wdata_o,
  input  logic            data_gnt_i,
  input  logic            data_rvalid_i,
  input  logic [XLEN-1:0] data_rdata_i
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  lsu_state_e      r_state;
  lsu_state_e      w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [1:0]      r_off;
  logic [2:0]      r_size;
  logic            r_we;

  logic            w_aligned;
  logic            w_timeout;
  logic            w_take;
  logic            w_req;
  logic            w_stall;
  logic            w_done;
  logic            w_misalign;
  logic            w_bus_err;
  lsu_bus_req_t    w_bus;
  logic [XLEN-1:0] w_load_res;

  assign w_aligned = lsu_is_aligned(lsu_size_i, lsu_addr_i[1:0]);
  assign w_timeout = (BUS_TIMEOUT != 0) && (r_cnt == CNT_W'(BUS_TIMEOUT - 1));

  // Bus payload from the (held) instruction operands
  always_comb begin
    w_bus       = '0;
    w_bus.we    = lsu_we_i;
    w_bus.addr  = {lsu_addr_i[XLEN-1:2], 2'b00};
    case (lsu_size_i)
      MEM_B, MEM_BU: begin
        w_bus.be    = 4'b0001 << lsu_addr_i[1:0];
        w_bus.wdata = {4{lsu_wdata_i[7:0]}};
      end
      MEM_H, MEM_HU: begin
        w_bus.be    = 4'b0011 << lsu_addr_i[1:0];
        w_bus.wdata = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        w_bus.be    = 4'b1111;
        w_bus.wdata = lsu_wdata_i;
      end
    endcase
  end

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_d  = r_state;
    w_take     = 1'b0;
    w_req      = 1'b0;
    w_stall    = 1'b0;
    w_done     = 1'b0;
    w_misalign = 1'b0;
    w_bus_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (lsu_req_i) begin
          if (w_aligned) begin
            w_req     = 1'b1;
            w_stall   = 1'b1;
            w_take    = 1'b1;
            w_state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end else begin
            w_misalign = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        if (w_timeout) begin
          w_bus_err = 1'b1;
          w_state_d = IDLE;
        end else begin
          w_req   = 1'b1;
          w_stall = 1'b1;
          if (data_gnt_i) w_state_d = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          w_done    = 1'b1;
          w_state_d = IDLE;
        end else if (w_timeout) begin
          w_bus_err = 1'b1;
          w_state_d = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Timeout counter restarts at each new access and runs until return to IDLE
  assign w_cnt_d = ((r_state == IDLE) || (w_state_d == IDLE)) ? '0 : r_cnt + CNT_W'(1);

  // State, timeout counter and captured access attributes
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_off   <= 2'b00;
      r_size  <= 3'b000;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_take) begin
        r_off  <= lsu_addr_i[1:0];
        r_size <= lsu_size_i;
        r_we   <= lsu_we_i;
      end
    end
  end

  miriscv_lsu_load_ext u_load_ext (
    .i_rdata  (data_rdata_i),
    .i_off    (r_off),
    .i_size   (r_size),
    .o_result (w_load_res)
  );

  // Outputs forced low while reset is asserted, even with a live request input
  assign data_req_o      = arstn_i & w_req;
  assign data_we_o       = arstn_i & w_req & w_bus.we;
  assign data_be_o       = (arstn_i & w_req) ? w_bus.be    : 4'b0000;
  assign data_addr_o     = (arstn_i & w_req) ? w_bus.addr  : '0;
  assign data_wdata_o    = (arstn_i & w_req) ? w_bus.wdata : '0;
  assign lsu_stall_req_o = arstn_i & w_stall;
  assign lsu_done_o      = arstn_i & w_done;
  assign lsu_misalign_o  = arstn_i & w_misalign;
  assign lsu_bus_err_o   = arstn_i & w_bus_err;
  assign lsu_rdata_o     = (arstn_i & w_done & ~r_we) ? w_load_res : '0;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Scoreboard bench for miriscv_lsu with a cycle-driven bus responder.
module tb_miriscv_lsu;
  import miriscv_lsu_pkg::*;

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_MIS  = 3'b010;
  localparam logic [2:0] K_ERR  = 3'b100;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] rdata;
  } sb_item_t;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic        lsu_done_o, lsu_stall_req_o, lsu_misalign_o, lsu_bus_err_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  int n_checks = 0;
  int n_errors = 0;
  sb_item_t sb_q[$];

  always #5 clk_i = ~clk_i;

  miriscv_lsu #(.BUS_TIMEOUT(8)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o),
    .lsu_done_o(lsu_done_o), .lsu_stall_req_o(lsu_stall_req_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_bus_err_o(lsu_bus_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference byte enables / lane data / load extension
  function automatic logic [3:0] ref_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      MEM_B, MEM_BU: case (off) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                                2'd2: return 4'b0100; default: return 4'b1000; endcase
      MEM_H, MEM_HU: return off[1] ? 4'b1100 : 4'b0011;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size)
      MEM_B, MEM_BU: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      MEM_H, MEM_HU: return {d[15:0], d[15:0]};
      default:       return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      MEM_B:   return b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
      MEM_BU:  return {24'h0, b};
      MEM_H:   return h[15] ? {16'hFFFF, h} : {16'h0, h};
      MEM_HU:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Scoreboard: every completion/fault pulse must match the oldest pending entry
  always @(negedge clk_i) begin
    sb_item_t e;
    if (arstn_i) begin
      if (lsu_done_o | lsu_misalign_o | lsu_bus_err_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_event", {29'd0, lsu_bus_err_o, lsu_misalign_o, lsu_done_o}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("event_kind", {29'd0, lsu_bus_err_o, lsu_misalign_o, lsu_done_o}, {29'd0, e.kind});
          chk("load_result", lsu_rdata_o, e.rdata);
        end
      end else begin
        chk("rdata_idle_zero", lsu_rdata_o, 32'd0);
      end
    end
  end

  // Issue one access and play the bus responder until the LSU reports an outcome
  task automatic run_acc(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rword, input logic [2:0] kind,
                         input int exp_req, input int exp_stall);
    int nreq, nstall, cyc, rsp;
    bit granted, fin;
    sb_item_t e;
    nreq = 0; nstall = 0; cyc = 0; rsp = 0; granted = 0; fin = 0;
    e.kind  = kind;
    e.rdata = (kind == K_DONE && !we) ? ref_load(size, addr[1:0], rword) : 32'd0;
    sb_q.push_back(e);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    while (!fin && cyc < 64) begin
      data_gnt_i    = !granted && (nreq == gnt_dly);
      data_rvalid_i = granted ? (rsp == rv_dly) : (nreq == 1);
      data_rdata_i  = (granted && rsp == rv_dly) ? rword : $urandom();
      @(negedge clk_i);
      if (data_req_o) begin
        if (nreq == 0) begin
          chk("bus_be", {28'd0, data_be_o}, {28'd0, ref_be(size, addr[1:0])});
          chk("bus_addr", data_addr_o, {addr[31:2], 2'b00});
          chk("bus_we", {31'd0, data_we_o}, {31'd0, we});
          if (we) chk("bus_wdata", data_wdata_o, ref_wdata(size, wdata));
        end
        nreq++;
      end
      if (lsu_stall_req_o) nstall++;
      if (lsu_done_o | lsu_misalign_o | lsu_bus_err_o) fin = 1;
      if (granted) rsp++;
      if (data_req_o && data_gnt_i) granted = 1;
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("access_finished", {31'd0, fin}, 32'd1);
    chk("req_cycles", nreq, exp_req);
    chk("stall_cycles", nstall, exp_stall);
    lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, data_req_o, data_we_o, lsu_stall_req_o,
                        lsu_done_o, lsu_misalign_o, lsu_bus_err_o}, 32'd0);
    chk({tag, "_be"}, {28'd0, data_be_o}, 32'd0);
    chk({tag, "_addr"}, data_addr_o, 32'd0);
    chk({tag, "_wdata"}, data_wdata_o, 32'd0);
    chk({tag, "_rdata"}, lsu_rdata_o, 32'd0);
  endtask

  initial begin
    arstn_i = 1'b0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = MEM_W;
    lsu_addr_i = 32'h100; lsu_wdata_i = 32'h0;
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h0;
    @(negedge clk_i);
    chk_all_zero("reset");
    lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(posedge clk_i); #1 arstn_i = 1'b1;
    @(posedge clk_i); #1;

    run_acc(1'b0, MEM_W,  32'h100, 32'h0,        0, 0, 32'hDEADBEEF, K_DONE, 1, 1);
    run_acc(1'b0, MEM_B,  32'h103, 32'h0,        0, 0, 32'h80123456, K_DONE, 1, 1);
    run_acc(1'b0, MEM_BU, 32'h103, 32'h0,        1, 2, 32'h80123456, K_DONE, 2, 4);
    run_acc(1'b1, MEM_H,  32'h202, 32'h1234ABCD, 3, 0, 32'h55AA55AA, K_DONE, 4, 4);
    run_acc(1'b0, MEM_H,  32'h002, 32'h0,        0, 1, 32'h80011234, K_DONE, 1, 2);
    run_acc(1'b0, MEM_HU, 32'h006, 32'h0,        2, 0, 32'h80015678, K_DONE, 3, 3);
    run_acc(1'b1, MEM_B,  32'h013, 32'h000000A5, 0, 0, 32'h0,        K_DONE, 1, 1);
    run_acc(1'b1, MEM_W,  32'h020, 32'hCAFEF00D, 1, 1, 32'h0,        K_DONE, 2, 3);
    run_acc(1'b0, 3'b011, 32'h024, 32'h0,        0, 0, 32'h13579BDF, K_DONE, 1, 1);
    run_acc(1'b0, MEM_W,  32'h101, 32'h0,        0, 0, 32'h0,        K_MIS,  0, 0);
    run_acc(1'b1, MEM_H,  32'h003, 32'hFFFF,     0, 0, 32'h0,        K_MIS,  0, 0);
    run_acc(1'b0, MEM_B,  32'h007, 32'h0,        0, 7, 32'h0000007F, K_DONE, 1, 8);
    run_acc(1'b0, MEM_W,  32'h300, 32'h0,     1000, 0, 32'h0,        K_ERR,  8, 8);

    // Late response after the timeout must be ignored
    repeat (2) begin
      data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0BAD0;
      @(negedge clk_i);
      chk("late_rvalid_done", {31'd0, lsu_done_o}, 32'd0);
      chk("late_rvalid_stall", {31'd0, lsu_stall_req_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    data_rvalid_i = 1'b0;
    run_acc(1'b0, MEM_W,  32'h304, 32'h0,        0, 1000, 32'h0,     K_ERR,  1, 8);

    // Reset while waiting for the response abandons the access
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = MEM_W; lsu_addr_i = 32'h400;
    data_gnt_i = 1'b1;
    @(posedge clk_i); #1 data_gnt_i = 1'b0;
    chk("pre_reset_stall", {31'd0, lsu_stall_req_o}, 32'd1);
    arstn_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111;
    @(negedge clk_i);
    chk_all_zero("mid_reset");
    @(posedge clk_i); #1;
    arstn_i = 1'b1; lsu_req_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    chk("post_reset_done", {31'd0, lsu_done_o}, 32'd0);
    @(posedge clk_i); #1 data_rvalid_i = 1'b0;
    run_acc(1'b0, MEM_H,  32'h010, 32'h0,        0, 0, 32'h1234F00D, K_DONE, 1, 1);

    repeat (2) @(posedge clk_i);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
